// File: rtl/rr_merge4x16.sv
// rr_merge4x16: four 16-bit valid/ready channels merged round-robin into one
// registered valid/ready output stream tagged with the source channel index.

// Per-channel handshake: a channel is told ready only when it holds the grant
// and the output register can take a word this cycle.
module rr_merge4x16_lane #(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic       reset,
  input  logic       load_en,
  input  logic       gnt_any,
  input  logic [1:0] gnt_idx,
  output logic       ready
);

  // Grant match is gated by reset so nothing is accepted in a reset cycle.
  always_comb begin
    ready = !reset && load_en && gnt_any && (gnt_idx == IDX);
  end

endmodule

module rr_merge4x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic        a_valid,
  input  logic        b_valid,
  input  logic        c_valid,
  input  logic        d_valid,
  output logic        a_ready,
  output logic        b_ready,
  output logic        c_ready,
  output logic        d_ready,
  output logic [15:0] out,
  output logic [1:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;

  logic [NUM_LANES-1:0][VEC_W-1:0] dat;
  logic [NUM_LANES-1:0]            vld;
  logic [NUM_LANES-1:0]            rdy;
  logic [1:0]                      ptr;
  logic                            load_en;
  logic                            gnt_any;
  logic [1:0]                      gnt_idx;

  assign dat = {d, c, b, a};
  assign vld = {d_valid, c_valid, b_valid, a_valid};
  assign {d_ready, c_ready, b_ready, a_ready} = rdy;

  // Register is free when empty or being drained in the same cycle.
  assign load_en = !out_valid || out_ready;

  // Scan from ptr upward (mod 4); walking offsets high-to-low leaves the
  // nearest valid channel to ptr as the winner.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rr_merge4x16_lane #(.IDX(2'(g))) u_lane (
        .reset   (reset),
        .load_en (load_en),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx),
        .ready   (rdy[g])
      );
    end
  endgenerate

  // Output register and priority pointer; pointer moves past the winner only
  // when a word is actually taken, so a stalled stream keeps its fairness order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_sel   <= 2'b00;
      out_valid <= 1'b0;
      ptr       <= 2'b00;
    end else if (load_en) begin
      if (gnt_any) begin
        out       <= dat[gnt_idx];
        out_sel   <= gnt_idx;
        out_valid <= 1'b1;
        ptr       <= gnt_idx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_merge4x16.sv
// Directed self-checking bench for rr_merge4x16.
module tb_rr_merge4x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b, c, d;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [15:0] out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic [3:0]  rdy;
  logic [18:0] obs;

  assign rdy = {d_ready, c_ready, b_ready, a_ready};
  assign obs = {out_valid, out_sel, out};

  rr_merge4x16 dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .out(out), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Drive valids {d,c,b,a} and out_ready, then let combinational paths settle.
  task automatic drive(input logic [3:0] v, input logic ordy);
    {d_valid, c_valid, b_valid, a_valid} = v;
    out_ready = ordy;
    #1;
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0000, 1'b1);
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
    reset = 1'b1;
    drive(4'b1111, 1'b1);
    checks++;
    if (rdy !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b0, 2'b00, 16'h0000}) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, {1'b0, 2'b00, 16'h0000});
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    c = 16'hC5B7;
    drive(4'b0100, 1'b1);
    checks++;
    if (rdy !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b want 0100", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'b10, 16'hC5B7}) begin
      errors++; $display("FAIL single_out: got %h want %h", obs, {1'b1, 2'b10, 16'hC5B7});
    end
    // ptr should now be 11: with everyone valid, d wins.
    a = 16'hA001; b = 16'hB002; d = 16'hD004;
    drive(4'b1111, 1'b1);
    checks++;
    if (rdy !== 4'b1000) begin
      errors++; $display("FAIL single_ptr_ready: got %b want 1000", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'b11, 16'hD004}) begin
      errors++; $display("FAIL single_ptr_out: got %h want %h", obs, {1'b1, 2'b11, 16'hD004});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_sel [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [15:0] exp_dat [5] = '{16'h0A0A, 16'h1B1B, 16'h2C2C, 16'h3D3D, 16'h0A0A};
    logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    a = 16'h0A0A; b = 16'h1B1B; c = 16'h2C2C; d = 16'h3D3D;
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdy !== exp_rdy[i]) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, rdy, exp_rdy[i]);
      end
      tick();
      checks++;
      if (obs !== {1'b1, exp_sel[i], exp_dat[i]}) begin
        errors++; $display("FAIL rr_out[%0d]: got %h want %h", i, obs, {1'b1, exp_sel[i], exp_dat[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a = 16'hA5A5; b = 16'hB6B6; d = 16'h6BDE;
    drive(4'b1000, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b1, 2'b11, 16'h6BDE}) begin
      errors++; $display("FAIL bp_load: got %h want %h", obs, {1'b1, 2'b11, 16'h6BDE});
    end
    drive(4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, rdy);
      end
      tick();
      checks++;
      if (obs !== {1'b1, 2'b11, 16'h6BDE}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, {1'b1, 2'b11, 16'h6BDE});
      end
    end
    drive(4'b0011, 1'b1);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL bp_release_ready: got %b want 0001", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'b00, 16'hA5A5}) begin
      errors++; $display("FAIL bp_release_out: got %h want %h", obs, {1'b1, 2'b00, 16'hA5A5});
    end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    b = 16'h0B0B; c = 16'h0C0C;
    drive(4'b0100, 1'b1);
    tick();
    drive(4'b0010, 1'b1);
    checks++;
    if (rdy !== 4'b0010) begin
      errors++; $display("FAIL wrap_ready: got %b want 0010", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'b01, 16'h0B0B}) begin
      errors++; $display("FAIL wrap_out: got %h want %h", obs, {1'b1, 2'b01, 16'h0B0B});
    end
    drive(4'b0000, 1'b1);
    checks++;
    if (rdy !== 4'b0000) begin
      errors++; $display("FAIL drain_ready: got %b want 0000", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b0, 2'b01, 16'h0B0B}) begin
      errors++; $display("FAIL drain_out: got %h want %h", obs, {1'b0, 2'b01, 16'h0B0B});
    end
    // ptr should be 10 and unchanged by the empty cycle: c wins next.
    drive(4'b1111, 1'b1);
    checks++;
    if (rdy !== 4'b0100) begin
      errors++; $display("FAIL wrap_ptr_ready: got %b want 0100", rdy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    a = 16'hFFFF; d = 16'hD00D;
    drive(4'b0001, 1'b1);
    tick();
    checks++;
    if (obs !== {1'b1, 2'b00, 16'hFFFF}) begin
      errors++; $display("FAIL midrst_load: got %h want %h", obs, {1'b1, 2'b00, 16'hFFFF});
    end
    // Advance ptr away from a so the post-reset grant proves ptr was cleared.
    a = 16'h1234;
    drive(4'b0001, 1'b1);
    tick();
    reset = 1'b1;
    drive(4'b1001, 1'b1);
    checks++;
    if (rdy !== 4'b0000) begin
      errors++; $display("FAIL midrst_ready: got %b want 0000", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b0, 2'b00, 16'h0000}) begin
      errors++; $display("FAIL midrst_state: got %h want %h", obs, {1'b0, 2'b00, 16'h0000});
    end
    reset = 1'b0;
    drive(4'b1001, 1'b1);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL midrst_grant: got %b want 0001", rdy);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'b00, 16'h1234}) begin
      errors++; $display("FAIL midrst_out: got %h want %h", obs, {1'b1, 2'b00, 16'h1234});
    end
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    {d_valid, c_valid, b_valid, a_valid} = 4'b0000;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_merge4x16.md
# rr_merge4x16

Four-channel, 16-bit round-robin merge stage: collects words from four valid/ready producer channels, arbitrates fairly between them and delivers one word per cycle on a single registered valid/ready output. It generates the 2-bit channel select and performs the 4-way 16-bit selection internally. It sits directly upstream of any single-port consumer that needs four sources funnelled into one stream, and reports which channel each word came from.

## Interface
- No parameters: data width fixed at 16, channel count fixed at 4.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a, b, c, d  input  16 each  channel 0..3 data.
- a_valid, b_valid, c_valid, d_valid  input  1 each  channel 0..3 word present.
- a_ready, b_ready, c_ready, d_ready  output  1 each  channel 0..3 word accepted this cycle (combinational).
- out  output  16  registered merged data.
- out_sel  output  2  source channel of `out` (00=a, 01=b, 10=c, 11=d).
- out_valid  output  1  `out`/`out_sel` hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

## Operation
- State: output register {out, out_sel, out_valid}; 2-bit priority pointer `ptr`.
- Reset, sampled at a rising edge: out=16'h0000, out_sel=2'b00, out_valid=0, ptr=2'b00. All *_ready are 0 while reset=1.
- load_en = !out_valid || out_ready: the register is empty or is being drained this cycle.
- Arbitration, combinational: scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4); grant = first with valid=1. Without any valid input there is no grant.
- Granted channel's ready = load_en; all other readies = 0. A ready is never 1 for a channel whose valid is 0.
- On a clock edge with load_en and a grant: out <= granted data, out_sel <= grant index, out_valid <= 1, ptr <= grant+1 mod 4 (wraps 3 -> 0).
- On a clock edge with load_en and no grant: out_valid <= 0; out, out_sel and ptr hold.
- With out_valid=1 and out_ready=0: out, out_sel, out_valid and ptr all hold. No ready is asserted.
- Transfer on either side occurs only at an edge where valid and ready are both 1.
- Producers hold data and valid until accepted. A valid that is dropped before acceptance loses nothing and raises no error.
- Fairness: a channel that keeps valid asserted is granted within 4 output transfers.

## Timing
- Latency: input accepted at edge N -> visible on out/out_valid after edge N, through edge N+1 at least.
- Throughput: with out_ready held 1, one word per cycle, with no bubble between back-to-back grants.
- Backpressure: with out_ready=0, readies drop the same cycle (combinational path out_valid/out_ready -> *_ready).
- Simultaneous drain and load in one cycle is the normal case; out_valid stays 1.
- Reset asserted mid-stream: the held word is discarded at that edge and no input is accepted in that cycle. The first grant after reset release starts from channel a.
- No combinational path from any data input to `out`.

## Test plan
- Reset: assert reset with all valids=1 and out_ready=1 -> all readies=0; after the edge, out=0000, out_sel=00, out_valid=0.
- Single channel: only c_valid=1, c=16'hC5B7, out_ready=1 -> c_ready=1; next cycle out=C5B7, out_sel=10, out_valid=1, ptr=11.
- Round robin: all four valid continuously, out_ready=1, from reset -> out_sel sequence 00,01,10,11,00 on consecutive cycles, one ready high per cycle.
- Backpressure: out holds 16'h6BDE (sel 11) and out_ready=0 for 3 cycles with a_valid=b_valid=1 -> out unchanged, a_ready=b_ready=0; raise out_ready -> a_ready=1 that cycle, out=a next cycle.
- Skip/wrap: ptr=11 with only b_valid=1 -> grant b, out_sel=01, ptr becomes 10; then no valids -> out_valid falls to 0 after the drain edge.
- Mid-stream reset: out_valid=1 holding 16'hFFFF, reset for one cycle -> out_valid=0, out=0000, out_sel=00; with a_valid=d_valid=1 afterwards, the first grant is a.
